// File: rtl/if_stage.sv
// if_stage: serial instruction fetch with branch redirect and wrong-path discard
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic        br_taken, br_seen, br_evt, br_buf_valid, cancel, enter;
  logic [31:0] br_target, br_buf_target, npc_r, req_addr_r, fs_pc, inst_buf, inst;
  assign {br_taken, br_target} = br_bus;
  assign br_evt = br_taken & ~br_seen;
  assign enter = (state_n == REQ) && (state != REQ);
  assign inst_sram_req = state == REQ;
  assign inst_sram_addr = req_addr_r;
  assign inst_sram_wr = 1'b0;
  assign inst_sram_size = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;
  assign fs_to_ds_bus = {inst, fs_pc};
  always_comb begin
    state_n = state;
    fs_to_ds_valid = 1'b0;
    inst = inst_buf;
    case (state)
      IDLE: state_n = REQ;
      REQ:  state_n = inst_sram_addr_ok ? WAIT : REQ;
      WAIT: if (inst_sram_data_ok) begin
        if (cancel || br_evt) state_n = REQ;
        else if (ds_allowin) begin
          state_n = REQ;
          fs_to_ds_valid = 1'b1;
          inst = inst_sram_rdata;
        end else state_n = HOLD;
      end
      HOLD: begin
        fs_to_ds_valid = ~br_evt;
        state_n = (br_evt || ds_allowin) ? REQ : HOLD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      br_seen <= 1'b0;
      br_buf_valid <= 1'b0;
      br_buf_target <= '0;
      cancel <= 1'b0;
      npc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
      fs_pc <= '0;
      inst_buf <= '0;
    end else begin
      state <= state_n;
      br_seen <= ds_allowin ? 1'b0 : (br_seen | br_taken);
      if (br_evt) begin
        br_buf_valid <= 1'b1;
        br_buf_target <= br_target;
      end else if (enter) br_buf_valid <= 1'b0;
      if (enter) req_addr_r <= br_buf_valid ? br_buf_target : npc_r;
      if (state == REQ && inst_sram_addr_ok) begin
        fs_pc <= req_addr_r;
        npc_r <= req_addr_r + 32'd4;
      end
      if (state == WAIT && inst_sram_data_ok && !cancel && !br_evt && !ds_allowin) inst_buf <= inst_sram_rdata;
      // every redirect poisons whatever fetch is in flight or about to issue
      cancel <= br_evt | (cancel & ~(state == WAIT && inst_sram_data_ok));
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of if_stage against a small SRAM model
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  int checks = 0;
  int errors = 0;
  int addr_delay, data_lat, acnt, dcnt, cyc;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] acc[$];
  logic [63:0] deliv[$];
  int dcyc[$];

  if_stage dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'ha5a50000;
  endfunction

  assign inst_sram_addr_ok = inst_sram_req && !pend && acnt >= addr_delay;
  assign inst_sram_data_ok = pend && dcnt >= data_lat;
  assign inst_sram_rdata = inst_sram_data_ok ? f(pend_addr) : 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      acnt <= 0;
      dcnt <= 0;
      pend <= 1'b0;
    end else begin
      if (inst_sram_addr_ok) begin
        acnt <= 0;
        pend <= 1'b1;
        pend_addr <= inst_sram_addr;
        dcnt <= 1;
      end else begin
        if (inst_sram_req) acnt <= acnt + 1;
        if (inst_sram_data_ok) pend <= 1'b0;
        else if (pend) dcnt <= dcnt + 1;
      end
      if (inst_sram_req && inst_sram_addr_ok) acc.push_back(inst_sram_addr);
      if (fs_to_ds_valid && ds_allowin) begin
        deliv.push_back(fs_to_ds_bus);
        dcyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    br_bus = '0;
    ds_allowin = 1'b1;
    addr_delay = 0;
    data_lat = 1;
    repeat (2) @(negedge clk);
    acc.delete();
    deliv.delete();
    dcyc.delete();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("wait_acc", 96'(acc.size() >= n), 96'd1);
  endtask

  task automatic wait_deliv(input int n);
    int k = 0;
    while (deliv.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("wait_deliv", 96'(deliv.size() >= n), 96'd1);
  endtask

  task automatic chk_deliv(input string tag, input int i, input logic [31:0] pc);
    chk(tag, deliv[i], {f(pc), pc});
  endtask

  initial begin
    cyc = 0;
    // 1: reset values, first request, back-to-back fetch
    reset = 1'b1;
    br_bus = '0;
    ds_allowin = 1'b1;
    addr_delay = 0;
    data_lat = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {inst_sram_req, fs_to_ds_valid}, 2'b00);
    chk("rst_consts", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}, {1'b0, 2'd2, 4'd0, 32'd0});
    reset = 1'b0;
    @(negedge clk); #1;
    chk("t1_first_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000000});
    wait_deliv(3);
    chk("t1_acc0", acc[0], 32'h1c000000);
    chk("t1_acc1", acc[1], 32'h1c000004);
    chk("t1_acc2", acc[2], 32'h1c000008);
    chk_deliv("t1_d0", 0, 32'h1c000000);
    chk_deliv("t1_d1", 1, 32'h1c000004);
    chk_deliv("t1_d2", 2, 32'h1c000008);
    chk("t1_rate01", 96'(dcyc[1] - dcyc[0]), 96'd2);
    chk("t1_rate12", 96'(dcyc[2] - dcyc[1]), 96'd2);
    // 2: delayed addr_ok keeps request and address stable
    do_reset();
    addr_delay = 3;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_req_stable", {inst_sram_req, inst_sram_addr, fs_to_ds_valid}, {1'b1, 32'h1c000000, 1'b0});
      chk("t2_addr_ok", inst_sram_addr_ok, i == 3);
      @(negedge clk);
    end
    #1;
    chk("t2_deliver", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, f(32'h1c000000), 32'h1c000000});
    // 3: ID stalled when data arrives, instruction held
    do_reset();
    ds_allowin = 1'b0;
    @(negedge clk); #1;
    chk("t3_req", {inst_sram_req, inst_sram_addr_ok}, 2'b11);
    @(negedge clk); #1;
    chk("t3_wait_valid", {fs_to_ds_valid, inst_sram_data_ok}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t3_hold", {fs_to_ds_valid, inst_sram_req, fs_to_ds_bus}, {1'b1, 1'b0, f(32'h1c000000), 32'h1c000000});
    end
    ds_allowin = 1'b1;
    @(negedge clk); #1;
    chk("t3_next_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000004});
    chk("t3_handoff", 96'(deliv.size()), 96'd1);
    // 4: branch during WAIT drops the in-flight instruction
    do_reset();
    data_lat = 2;
    wait_acc(3);
    br_bus = {1'b1, 32'h1c000100};
    #1;
    chk("t4_in_wait", {acc[2], inst_sram_data_ok, fs_to_ds_valid}, {32'h1c000008, 2'b00});
    @(negedge clk);
    br_bus = '0;
    #1;
    chk("t4_drop", {inst_sram_data_ok, fs_to_ds_valid}, 2'b10);
    wait_deliv(4);
    chk("t4_acc3", acc[3], 32'h1c000100);
    chk("t4_acc4", acc[4], 32'h1c000104);
    chk_deliv("t4_d1", 1, 32'h1c000004);
    chk_deliv("t4_d2", 2, 32'h1c000100);
    chk_deliv("t4_d3", 3, 32'h1c000104);
    // 5: branch held in stalled ID redirects once, target delivered later
    do_reset();
    wait_deliv(1);
    br_bus = {1'b1, 32'h1c000200};
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_no_valid", fs_to_ds_valid, 1'b0);
      @(negedge clk);
    end
    br_bus = '0;
    #1;
    chk("t5_no_valid_d", fs_to_ds_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t5_hold", {fs_to_ds_valid, fs_to_ds_bus}, {1'b1, f(32'h1c000200), 32'h1c000200});
    end
    ds_allowin = 1'b1;
    wait_deliv(3);
    chk("t5_acc1", acc[1], 32'h1c000004);
    chk("t5_acc2", acc[2], 32'h1c000200);
    chk("t5_acc3", acc[3], 32'h1c000204);
    chk_deliv("t5_d1", 1, 32'h1c000200);
    chk_deliv("t5_d2", 2, 32'h1c000204);
    // 6: reset in WAIT with data_ok restarts fetch
    do_reset();
    wait_acc(3);
    #1;
    chk("t6_wait_data", {inst_sram_data_ok, acc[2]}, {1'b1, 32'h1c000008});
    reset = 1'b1;
    @(negedge clk); #1;
    chk("t6_reset_out", {fs_to_ds_valid, inst_sram_req}, 2'b00);
    acc.delete();
    deliv.delete();
    reset = 1'b0;
    @(negedge clk); #1;
    chk("t6_restart", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1c000000});
    wait_deliv(1);
    chk_deliv("t6_d0", 0, 32'h1c000000);
    // PC wraps past the top of the address space
    do_reset();
    wait_deliv(1);
    br_bus = {1'b1, 32'hfffffffc};
    @(negedge clk);
    br_bus = '0;
    wait_deliv(3);
    chk_deliv("wrap_d1", 1, 32'hfffffffc);
    chk_deliv("wrap_d2", 2, 32'h00000000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
